// File: rtl/uart_packet_rx.sv
// uart_packet_rx: 8N1 UART receiver for the instruction-load path.
// Each received byte is presented on uart_packet and handed over with a
// four-phase packet_ready/packet_ack handshake. Framing and overrun errors
// are reported on sticky flags that clear only on reset.
module uart_packet_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       packet_ack,
    output logic       packet_ready,
    output logic [7:0] uart_packet,
    output logic       frame_err,
    output logic       overrun_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    // Terminal counts: half a bit to reach mid-start-bit, then whole bits.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    // Receive FSM encoding
    localparam logic [2:0] RX_IDLE  = 3'd0;
    localparam logic [2:0] RX_START = 3'd1;
    localparam logic [2:0] RX_DATA  = 3'd2;
    localparam logic [2:0] RX_STOP  = 3'd3;
    localparam logic [2:0] RX_BREAK = 3'd4;

    // Output handshake FSM encoding
    localparam logic [1:0] OUT_EMPTY = 2'd0;
    localparam logic [1:0] OUT_VALID = 2'd1;
    localparam logic [1:0] OUT_DRAIN = 2'd2;

    logic             rx_meta_q;
    logic             rx_s_q;
    logic [2:0]       rx_state_q,  rx_state_d;
    logic [CNT_W-1:0] clk_cnt_q,   clk_cnt_d;
    logic [2:0]       bit_cnt_q,   bit_cnt_d;
    logic [7:0]       shift_q,     shift_d;
    logic [1:0]       out_state_q, out_state_d;
    logic [7:0]       packet_q,    packet_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q,   overrun_d;
    logic             byte_done;

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Receive FSM: mid-bit sampling of start, eight data bits and stop.
    always_comb begin
        rx_state_d  = rx_state_q;
        clk_cnt_d   = clk_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        frame_err_d = frame_err_q;
        byte_done   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_s_q) begin
                    rx_state_d = RX_START;
                    clk_cnt_d  = '0;
                    bit_cnt_d  = '0;
                end
            end
            RX_START: begin
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d  = '0;
                    rx_state_d = rx_s_q ? RX_IDLE : RX_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    if (rx_s_q) begin
                        byte_done  = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        rx_state_d  = RX_BREAK;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            RX_BREAK: begin
                if (rx_s_q) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    // Output FSM: latch a completed byte only when the output side is empty.
    always_comb begin
        out_state_d = out_state_q;
        packet_d    = packet_q;
        overrun_d   = overrun_q;
        case (out_state_q)
            OUT_EMPTY: begin
                if (byte_done) begin
                    packet_d    = shift_q;
                    out_state_d = OUT_VALID;
                end
            end
            OUT_VALID: begin
                if (byte_done) begin
                    overrun_d = 1'b1;
                end
                if (packet_ack) begin
                    out_state_d = OUT_DRAIN;
                end
            end
            OUT_DRAIN: begin
                if (byte_done) begin
                    overrun_d = 1'b1;
                end
                if (!packet_ack) begin
                    out_state_d = OUT_EMPTY;
                end
            end
            default: begin
                out_state_d = OUT_EMPTY;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_q  <= RX_IDLE;
            clk_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            out_state_q <= OUT_EMPTY;
            packet_q    <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            out_state_q <= out_state_d;
            packet_q    <= packet_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign packet_ready = (out_state_q == OUT_VALID);
    assign uart_packet  = packet_q;
    assign frame_err    = frame_err_q;
    assign overrun_err  = overrun_q;

endmodule
